// File: rtl/morse_letter_sequencer.sv
// Groups single-cycle dot/dash pulses into Morse letters, closes a letter after an inter-letter
// silence, inserts a space after an inter-word silence, and offers each result over valid/ready.
module morse_letter_sequencer #(
  parameter int MAX_SYMBOLS    = 5,
  parameter int GAP_TICKS      = 8,
  parameter int WORD_GAP_TICKS = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dot,
  input  logic                   dash,
  output logic [MAX_SYMBOLS-1:0] letter_pattern,
  output logic [2:0]             letter_len,
  output logic                   letter_valid,
  input  logic                   letter_ready,
  output logic                   overflow,
  output logic                   dropped
);

  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int WORD_W = $clog2(WORD_GAP_TICKS + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORD_GAP_TICKS - 1);
  localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1);
  localparam logic [2:0]        LEN_MAX   = 3'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISCARD,
    HOLD
  } state_t;

  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WORD_W-1:0] word_cnt;
  logic              word_armed;

  logic                   symbol;
  logic                   clash;
  logic                   accept;
  logic [MAX_SYMBOLS-1:0] first_pattern;

  // A simultaneous dot and dash is ambiguous, so it is treated as silence.
  assign symbol        = dot ^ dash;
  assign clash         = dot & dash;
  assign accept        = letter_valid & letter_ready;
  assign first_pattern = {{(MAX_SYMBOLS-1){1'b0}}, dash};

  // NOTE: all state here is sequential, so every assignment is non-blocking; blocking
  // assignments would let later statements see this cycle's new values and break the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      letter_pattern <= '0;
      letter_len     <= '0;
      letter_valid   <= 1'b0;
      overflow       <= 1'b0;
      dropped        <= 1'b0;
      gap_cnt        <= '0;
      word_cnt       <= '0;
      word_armed     <= 1'b0;
    end else begin
      if (clash) dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (symbol) begin
            letter_pattern <= first_pattern;
            letter_len     <= 3'd1;
            gap_cnt        <= '0;
            word_armed     <= 1'b0;
            state          <= COLLECT;
          end else if (word_armed) begin
            if (word_cnt == WORD_LAST) begin
              letter_pattern <= '0;
              letter_len     <= '0;
              letter_valid   <= 1'b1;
              word_armed     <= 1'b0;
              word_cnt       <= '0;
              state          <= HOLD;
            end else begin
              word_cnt <= word_cnt + WORD_ONE;
            end
          end
        end

        COLLECT: begin
          if (symbol) begin
            gap_cnt <= '0;
            if (letter_len == LEN_MAX) begin
              overflow <= 1'b1;
              state    <= DISCARD;
            end else begin
              letter_pattern <= {letter_pattern[MAX_SYMBOLS-2:0], dash};
              letter_len     <= letter_len + 3'd1;
            end
          end else if (gap_cnt == GAP_LAST) begin
            letter_valid <= 1'b1;
            gap_cnt      <= '0;
            state        <= HOLD;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end

        // An over-long letter is swallowed until the line has been quiet for a full letter gap.
        DISCARD: begin
          if (symbol) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            letter_pattern <= '0;
            letter_len     <= '0;
            gap_cnt        <= '0;
            state          <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end

        HOLD: begin
          if (accept) begin
            letter_valid <= 1'b0;
            if (symbol) begin
              letter_pattern <= first_pattern;
              letter_len     <= 3'd1;
              gap_cnt        <= '0;
              word_armed     <= 1'b0;
              state          <= COLLECT;
            end else begin
              // Only a real letter arms the word gap, so spaces never repeat back-to-back.
              word_armed     <= (letter_len != 3'd0);
              word_cnt       <= '0;
              letter_pattern <= '0;
              letter_len     <= '0;
              state          <= IDLE;
            end
          end else if (symbol) begin
            dropped <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Self-checking bench: directed Morse keying scenarios, a queue-based reference model
// compared every cycle, and literal expectations for the key scenarios.
module tb_morse_letter_sequencer;

  localparam int MAX  = 5;
  localparam int GAP  = 8;
  localparam int WORD = 20;

  logic           clock;
  logic           reset;
  logic           dot;
  logic           dash;
  logic [MAX-1:0] letter_pattern;
  logic [2:0]     letter_len;
  logic           letter_valid;
  logic           letter_ready;
  logic           overflow;
  logic           dropped;

  int n_cmp = 0;
  int n_bad = 0;

  morse_letter_sequencer #(
    .MAX_SYMBOLS   (MAX),
    .GAP_TICKS     (GAP),
    .WORD_GAP_TICKS(WORD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dot           (dot),
    .dash          (dash),
    .letter_pattern(letter_pattern),
    .letter_len    (letter_len),
    .letter_valid  (letter_valid),
    .letter_ready  (letter_ready),
    .overflow      (overflow),
    .dropped       (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: symbols of the open letter kept in a queue, silence measured as run lengths.
  bit m_valid, m_ovf, m_drop, m_disc, m_armed, live;
  int m_pat, m_len, idle_run, word_run;
  bit cur[$];

  initial begin
    live = 1'b0;
    forever begin
      @(negedge clock);
      if (live) begin
        check("model_valid", letter_valid, m_valid);
        check("model_overflow", overflow, m_ovf);
        check("model_dropped", dropped, m_drop);
        if (m_valid) begin
          check("model_pattern", letter_pattern, m_pat);
          check("model_len", letter_len, m_len);
        end
      end
      // Inputs are stable from here until the next rising edge samples them.
      if (reset) begin
        m_valid = 0; m_ovf = 0; m_drop = 0; m_disc = 0; m_armed = 0;
        m_pat = 0; m_len = 0; idle_run = 0; word_run = 0;
        cur.delete();
        live = 1'b1;
      end else if (live) begin
        bit sym;
        bit b;
        sym = dot ^ dash;
        b   = dash;
        if (dot && dash) m_drop = 1;
        if (m_valid) begin
          if (letter_ready) begin
            m_valid  = 0;
            m_armed  = (m_len > 0);
            word_run = 0;
            if (sym) begin
              cur.delete();
              cur.push_back(b);
              idle_run = 0;
              m_armed  = 0;
            end
          end else if (sym) begin
            m_drop = 1;
          end
        end else if (m_disc) begin
          if (sym) idle_run = 0;
          else begin
            idle_run++;
            if (idle_run == GAP) m_disc = 0;
          end
        end else if (cur.size() > 0) begin
          if (sym) begin
            idle_run = 0;
            if (cur.size() == MAX) begin
              m_ovf  = 1;
              m_disc = 1;
              cur.delete();
            end else begin
              cur.push_back(b);
            end
          end else begin
            idle_run++;
            if (idle_run == GAP) begin
              m_pat = 0;
              foreach (cur[i]) m_pat = m_pat * 2 + int'(cur[i]);
              m_len   = cur.size();
              m_valid = 1;
              cur.delete();
            end
          end
        end else begin
          if (sym) begin
            cur.push_back(b);
            idle_run = 0;
            m_armed  = 0;
          end else if (m_armed) begin
            word_run++;
            if (word_run == WORD) begin
              m_pat   = 0;
              m_len   = 0;
              m_valid = 1;
              m_armed = 0;
            end
          end
        end
      end
    end
  end

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic d, input logic h);
    dot  = d;
    dash = h;
    align();
    dot  = 1'b0;
    dash = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) align();
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (letter_valid) break;
    end
    check("valid_seen", letter_valid, 1);
  endtask

  task automatic count_valid(input int n, input string name, input int expected);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (letter_valid) seen++;
    end
    check(name, seen, expected);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi_k[$];
    int hi_pat[$];
    int hi_len[$];

    reset        = 1'b1;
    dot          = 1'b0;
    dash         = 1'b0;
    letter_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    check("reset_valid", letter_valid, 0);
    check("reset_len", letter_len, 0);
    check("reset_pattern", letter_pattern, 0);
    check("reset_overflow", overflow, 0);
    check("reset_dropped", dropped, 0);
    align();
    idle(1);

    // dot, dash, dash two cycles apart; letter, then exactly one space
    pulse(1, 0); idle(1);
    pulse(0, 1); idle(1);
    pulse(0, 1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (letter_valid) begin
        hi_k.push_back(k);
        hi_pat.push_back(int'(letter_pattern));
        hi_len.push_back(int'(letter_len));
      end
    end
    check("t1_valid_cycles", hi_k.size(), 2);
    if (hi_k.size() == 2) begin
      check("t1_latency", hi_k[0], GAP + 1);
      check("t1_pattern", hi_pat[0], 3);
      check("t1_len", hi_len[0], 3);
      check("t2_space_time", hi_k[1], GAP + 1 + WORD + 1);
      check("t2_space_len", hi_len[1], 0);
      check("t2_space_pattern", hi_pat[1], 0);
    end
    align();

    // letter held with ready low; extra symbols are lost
    letter_ready = 1'b0;
    pulse(0, 1);
    pulse(1, 0);
    wait_valid(40);
    align();
    for (int i = 0; i < 4; i++) begin
      pulse(0, 1);
      idle(1);
    end
    @(negedge clock);
    check("t3_valid_held", letter_valid, 1);
    check("t3_pattern", letter_pattern, 2);
    check("t3_len", letter_len, 2);
    check("t3_dropped", dropped, 1);
    align();
    letter_ready = 1'b1;
    count_valid(5, "t3_one_transfer", 1);
    align();
    idle(30);

    // six dots overflow; the following dash is a clean letter
    repeat (6) pulse(1, 0);
    count_valid(10, "t4_no_letter", 0);
    check("t4_overflow", overflow, 1);
    align();
    pulse(0, 1);
    wait_valid(40);
    check("t4_pattern", letter_pattern, 1);
    check("t4_len", letter_len, 1);
    align();
    idle(30);

    // accept and a new dot on the same edge
    letter_ready = 1'b0;
    pulse(0, 1);
    wait_valid(40);
    align();
    letter_ready = 1'b1;
    pulse(1, 0);
    @(negedge clock);
    check("t5_valid_dropped_after_accept", letter_valid, 0);
    wait_valid(40);
    check("t5_new_pattern", letter_pattern, 0);
    check("t5_new_len", letter_len, 1);
    align();
    idle(30);

    // reset mid-collect and mid-hold
    pulse(1, 0);
    pulse(0, 1);
    reset = 1'b1;
    align();
    reset = 1'b0;
    @(negedge clock);
    check("t6a_valid", letter_valid, 0);
    check("t6a_len", letter_len, 0);
    check("t6a_overflow", overflow, 0);
    check("t6a_dropped", dropped, 0);
    align();
    letter_ready = 1'b0;
    pulse(1, 0);
    wait_valid(40);
    align();
    reset = 1'b1;
    align();
    reset = 1'b0;
    @(negedge clock);
    check("t6b_valid", letter_valid, 0);
    check("t6b_len", letter_len, 0);
    check("t6b_pattern", letter_pattern, 0);
    check("t6b_dropped", dropped, 0);
    count_valid(25, "t6_no_space", 0);
    align();

    // simultaneous dot and dash: ignored but flagged
    letter_ready = 1'b1;
    pulse(1, 1);
    @(negedge clock);
    check("clash_dropped", dropped, 1);
    count_valid(15, "clash_no_letter", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
